// File: rtl/icache_refill_master_pkg.sv
// Shared definitions for the Icache refill master: TileLink-UL field
// encodings used on the A/D channels, the master's default source tag,
// the refill FSM state type and a line-alignment helper.
package icache_refill_master_pkg;

  localparam logic [2:0] TL_GET           = 3'd4;
  localparam logic [2:0] TL_ACCESSACKDATA = 3'd1;
  localparam logic [3:0] TL_SIZE_WORD     = 4'd2;
  localparam logic [4:0] SRC_ICACHE       = 5'b00010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } refill_state_e;

  // Line-aligned base of an address for a line of lw 32-bit words.
  function automatic logic [31:0] line_base(input logic [31:0] addr,
                                            input int unsigned lw);
    return addr & ~(32'(lw * 4) - 32'd1);
  endfunction

endpackage

// File: rtl/icache_refill_master_if.sv
// TileLink-UL style A/D channel bundle between the Icache refill master
// and the Icache-side SRAM bus slave.
//  master: drives A-channel request fields and D-channel ready
//  slave : drives A-channel ready and D-channel response fields
interface icache_refill_master_if;

  logic        aBitsValid;
  logic        aBitsReady;
  logic [31:0] aBitsAddress;
  logic [2:0]  aBitsOpcode;
  logic [3:0]  aBitsSize;
  logic [3:0]  aBitsMask;
  logic [31:0] aBitsData;
  logic [2:0]  aBitsParam;
  logic [4:0]  aBitsSource;
  logic        aBitsCorrupt;

  logic        dBitsValid;
  logic        dBitsReady;
  logic [2:0]  dBitsOpcode;
  logic [31:0] dBitsData;
  logic [4:0]  dBitsSource;
  logic        dBitsCorrupt;

  modport master (
    output aBitsValid, aBitsAddress, aBitsOpcode, aBitsSize, aBitsMask,
           aBitsData, aBitsParam, aBitsSource, aBitsCorrupt,
    input  aBitsReady,
    input  dBitsValid, dBitsOpcode, dBitsData, dBitsSource, dBitsCorrupt,
    output dBitsReady
  );

  modport slave (
    input  aBitsValid, aBitsAddress, aBitsOpcode, aBitsSize, aBitsMask,
           aBitsData, aBitsParam, aBitsSource, aBitsCorrupt,
    output aBitsReady,
    output dBitsValid, dBitsOpcode, dBitsData, dBitsSource, dBitsCorrupt,
    input  dBitsReady
  );

endinterface

// File: rtl/icache_refill_master_line_buffer.sv
// refill_line_buffer: LINE_WORDS x 32-bit line assembly registers.
//  clk, rst_n : clock, asynchronous active-low reset (clears all words)
//  i_we       : write strobe
//  i_idx      : word index to write
//  i_wdata    : word to write
//  o_flat     : whole line, word i at bits [32*i+31:32*i]
module refill_line_buffer #(
  parameter int unsigned LINE_WORDS = 4,
  localparam int unsigned CW = $clog2(LINE_WORDS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [CW-1:0]            i_idx,
  input  logic [31:0]              i_wdata,
  output logic [LINE_WORDS*32-1:0] o_flat
);

  logic [31:0] r_mem [LINE_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LINE_WORDS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  always_comb begin
    o_flat = '0;
    for (int unsigned i = 0; i < LINE_WORDS; i++) o_flat[32*i +: 32] = r_mem[i];
  end

endmodule

// File: rtl/icache_refill_master.sv
// icache_refill_master: refills one Icache line with LINE_WORDS single-word
// Get requests, one outstanding at a time, and returns the assembled line.
//  clk, rst_n          : clock, asynchronous active-low reset
//  miss_valid/addr     : refill request from the Icache (accepted in IDLE)
//  miss_ready          : high only while idle
//  flush               : abandon the current refill (no fill delivered)
//  fill_valid          : one-cycle pulse when the line is complete
//  fill_addr/data      : line base address and line data (held until next miss)
//  fill_error          : qualifies fill_valid (corrupt, bad opcode, timeout)
//  bus                 : A/D channel master side
module icache_refill_master
  import icache_refill_master_pkg::*;
#(
  parameter int unsigned LINE_WORDS  = 4,
  parameter logic [4:0]  SOURCE_ID   = SRC_ICACHE,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_valid,
  input  logic [31:0]              miss_addr,
  output logic                     miss_ready,
  input  logic                     flush,
  output logic                     fill_valid,
  output logic [31:0]              fill_addr,
  output logic [LINE_WORDS*32-1:0] fill_data,
  output logic                     fill_error,
  icache_refill_master_if.master   bus
);

  localparam int unsigned CW  = $clog2(LINE_WORDS);
  localparam int unsigned WDW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  refill_state_e r_state, w_state_nxt;

  logic [31:0]   r_base;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          r_kill;
  logic [WDW-1:0] r_wdog;

  logic w_miss_take;
  logic w_accept;
  logic w_last;
  logic w_timeout;
  logic w_kill_any;

  assign w_miss_take = miss_valid && !flush;
  assign w_accept    = (r_state == ST_WAIT) && bus.dBitsValid
                       && (bus.dBitsSource == SOURCE_ID);
  assign w_last      = (r_cnt == CW'(LINE_WORDS - 1));
  assign w_timeout   = (r_wdog == WDW'(TIMEOUT_CYC - 1));
  // A flush arriving in the same cycle as the drained beat must already
  // steer the FSM to DONE, before r_kill has been registered.
  assign w_kill_any  = r_kill || flush;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_miss_take) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (bus.aBitsReady) w_state_nxt = ST_WAIT;
        else if (flush)     w_state_nxt = ST_IDLE;
      end
      ST_WAIT: begin
        if (w_accept) begin
          if (w_last || w_kill_any) w_state_nxt = ST_DONE;
          else                      w_state_nxt = ST_REQ;
        end else if (w_timeout) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    miss_ready     = 1'b0;
    bus.aBitsValid = 1'b0;
    bus.dBitsReady = 1'b0;
    fill_valid     = 1'b0;
    fill_error     = 1'b0;
    unique case (r_state)
      ST_IDLE: miss_ready     = 1'b1;
      ST_REQ:  bus.aBitsValid = 1'b1;
      ST_WAIT: bus.dBitsReady = 1'b1;
      ST_DONE: begin
        fill_valid = !r_kill;
        fill_error = r_err && !r_kill;
      end
      default: ;
    endcase
  end

  // Refill bookkeeping: base, word counter, error, kill and watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_kill <= 1'b0;
      r_wdog <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_miss_take) begin
            r_base <= line_base(miss_addr, LINE_WORDS);
            r_cnt  <= '0;
            r_err  <= 1'b0;
          end
        end
        ST_REQ: begin
          if (bus.aBitsReady) begin
            r_wdog <= '0;
            if (flush) r_kill <= 1'b1;
          end
        end
        ST_WAIT: begin
          r_wdog <= r_wdog + WDW'(1);
          if (flush) r_kill <= 1'b1;
          if (w_accept) begin
            if (bus.dBitsCorrupt || (bus.dBitsOpcode != TL_ACCESSACKDATA))
              r_err <= 1'b1;
            if (!w_last) r_cnt <= r_cnt + CW'(1);
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        ST_DONE: r_kill <= 1'b0;
        default: ;
      endcase
    end
  end

  refill_line_buffer #(.LINE_WORDS(LINE_WORDS)) u_line_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_accept),
    .i_idx  (r_cnt),
    .i_wdata(bus.dBitsData),
    .o_flat (fill_data)
  );

  assign fill_addr = r_base;

  assign bus.aBitsAddress = r_base + {{(30 - CW){1'b0}}, r_cnt, 2'b00};
  assign bus.aBitsOpcode  = TL_GET;
  assign bus.aBitsSize    = TL_SIZE_WORD;
  assign bus.aBitsMask    = 4'b1111;
  assign bus.aBitsData    = '0;
  assign bus.aBitsParam   = '0;
  assign bus.aBitsSource  = SOURCE_ID;
  assign bus.aBitsCorrupt = 1'b0;

endmodule
